// File: rtl/rf_pkg.sv
// rf_pkg
//   Shared register-file constants and the write-back arbiter state type.
//   RF_ADDR_W   : register address width (32 registers)
//   RF_DATA_W   : register data width
//   RF_NUM_REGS : number of registers in the integer file
//   wb_state_t  : write-back arbiter states (INIT clear sequence, RUN)
package rf_pkg;

  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 32;

  typedef enum logic [0:0] {
    WB_INIT = 1'b0,
    WB_RUN  = 1'b1
  } wb_state_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if
//   Write-back request bus shared by NUM_REQ requesters.
//   req_valid : requester i has a write pending (bit i)
//   req_ready : requester i write accepted this cycle (bit i, one-hot)
//   req_addr  : destination register of requester i (slice i)
//   req_data  : write data of requester i (slice i)
//   master    : requester side; slave : arbiter side
interface regfile_wb_arbiter_if
  import rf_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter int DATA_W  = RF_DATA_W
) ();

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin pick. The search starts at index ptr and
//   wraps modulo NUM_REQ; the first requesting index wins.
//   req   : request vector
//   ptr   : index with highest priority this cycle (must be < NUM_REQ)
//   grant : one-hot winner, all-zero when req is zero
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  logic [NUM_REQ-1:0] rot_req;
  logic [NUM_REQ-1:0] rot_pick;

  // Rotate so that index ptr lands at bit 0, isolate the lowest set bit with
  // the two's-complement trick, then rotate the winner back into place.
  assign rot_req  = NUM_REQ'({req, req} >> ptr);
  assign rot_pick = rot_req & (~rot_req + ONE);
  assign grant    = NUM_REQ'(({rot_pick, rot_pick} << ptr) >> NUM_REQ);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Owns the single write port of the integer register file. After reset it
//   clears x1..x(NUM_REGS-1) (when INIT_CLEAR=1), then shares the write port
//   round-robin among NUM_REQ write-back requesters. The selected write is
//   registered, so the file sees it one cycle after the handshake.
//   clk       : clock, all state on the rising edge
//   reset     : synchronous, active-high
//   wb        : requester bus (slave side): req_valid/req_ready/req_addr/req_data
//   rf_we     : register file write enable
//   rf_waddr  : register file write address
//   rf_wdata  : register file write data
//   init_done : high once the clear sequence has finished
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_W     = RF_ADDR_W,
  parameter int DATA_W     = RF_DATA_W,
  parameter int NUM_REGS   = RF_NUM_REGS,
  parameter int INIT_CLEAR = 1
) (
  input  logic              clk,
  input  logic              reset,
  regfile_wb_arbiter_if.slave wb,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              init_done
);

  localparam int               PTR_W     = $clog2(NUM_REQ);
  localparam logic [0:0]       ST_INIT   = WB_INIT;
  localparam logic [0:0]       ST_RUN    = WB_RUN;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
  localparam logic [PTR_W-1:0] LAST_REQ  = PTR_W'(NUM_REQ - 1);

  logic [0:0]        state_reg;
  logic [ADDR_W-1:0] init_cnt_reg;
  logic [PTR_W-1:0]  rr_ptr_reg;
  logic              rf_we_reg;
  logic [ADDR_W-1:0] rf_waddr_reg;
  logic [DATA_W-1:0] rf_wdata_reg;
  logic              init_done_reg;

  logic [ADDR_W-1:0] addr_arr [NUM_REQ];
  logic [DATA_W-1:0] data_arr [NUM_REQ];

  logic [NUM_REQ-1:0] grant;
  logic               run_active;
  logic               transfer;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   rr_ptr_next;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign addr_arr[gi] = wb.req_addr[gi*ADDR_W +: ADDR_W];
      assign data_arr[gi] = wb.req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req   (wb.req_valid),
    .ptr   (rr_ptr_reg),
    .grant (grant)
  );

  // Reset is folded in so no requester sees an acceptance that the reset
  // edge is about to discard.
  assign run_active   = (state_reg == ST_RUN) && !reset;
  assign wb.req_ready = run_active ? grant : '0;
  assign transfer     = run_active && (|grant);

  // Grant is one-hot, so OR-ing masked slices is a clean mux.
  always_comb begin
    grant_idx = '0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_idx = PTR_W'(i);
      end
      sel_addr = sel_addr | (addr_arr[i] & {ADDR_W{grant[i]}});
      sel_data = sel_data | (data_arr[i] & {DATA_W{grant[i]}});
    end
  end

  assign rr_ptr_next = (grant_idx == LAST_REQ) ? '0 : grant_idx + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_INIT;
      init_cnt_reg  <= ADDR_W'(1);
      rr_ptr_reg    <= '0;
      rf_we_reg     <= 1'b0;
      rf_waddr_reg  <= '0;
      rf_wdata_reg  <= '0;
      init_done_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_INIT: begin
          if (INIT_CLEAR != 0) begin
            // x0 is hardwired zero, so the sweep starts at x1.
            rf_we_reg    <= 1'b1;
            rf_waddr_reg <= init_cnt_reg;
            rf_wdata_reg <= '0;
            init_cnt_reg <= init_cnt_reg + ADDR_W'(1);
            if (init_cnt_reg == LAST_ADDR) begin
              state_reg     <= ST_RUN;
              init_done_reg <= 1'b1;
            end
          end else begin
            rf_we_reg     <= 1'b0;
            state_reg     <= ST_RUN;
            init_done_reg <= 1'b1;
          end
        end
        default: begin
          if (transfer) begin
            rr_ptr_reg <= rr_ptr_next;
            // Writes to x0 complete the handshake but never reach the file.
            if (sel_addr != '0) begin
              rf_we_reg    <= 1'b1;
              rf_waddr_reg <= sel_addr;
              rf_wdata_reg <= sel_data;
            end else begin
              rf_we_reg <= 1'b0;
            end
          end else begin
            rf_we_reg <= 1'b0;
          end
        end
      endcase
    end
  end

  assign rf_we     = rf_we_reg;
  assign rf_waddr  = rf_waddr_reg;
  assign rf_wdata  = rf_wdata_reg;
  assign init_done = init_done_reg;

endmodule
